hyper_eot_classifier: RTL and testbench
=======================================

Name: hyper_eot_classifier

Overview:
- Per-channel end-of-transfer (EOT) classifier for the HyperBus uDMA macro, generalised to NB_CH chip-select channels.
- Each channel queues the direction (read or write) of every issued transfer in a small tag FIFO.
- On each hyper EOT the oldest tag is popped, and a read-EOT or write-EOT event is emitted to the uDMA event bus.
- It replaces the single "last direction" flop used today, which misclassifies EOTs once several transfers are outstanding or when RX and TX starts arrive together.

Parameters:
- NB_CH, 2, number of independent hyper channels (chip selects); must be ≥1.
- DEPTH, 4, tag FIFO entries per channel; must be ≥2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, do not override.

Ports:
- sys_clk_i  in  1  system clock; all logic is on the rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- clr_i  in  NB_CH  per-channel flush: empties the FIFO and clears the sticky errors.
- rx_start_i  in  NB_CH  one-cycle pulse: a read transfer was issued on channel c.
- tx_start_i  in  NB_CH  one-cycle pulse: a write transfer was issued on channel c.
- eot_i  in  NB_CH  one-cycle pulse: hyper controller end-of-transfer on channel c.
- evt_rd_eot_o  out  NB_CH  one-cycle pulse: read transfer completed.
- evt_wr_eot_o  out  NB_CH  one-cycle pulse: write transfer completed.
- pending_o  out  NB_CH*CNT_W  per-channel occupancy, packed with channel c at [c*CNT_W +: CNT_W].
- err_ovf_o  out  NB_CH  sticky: a start was dropped because the FIFO was full.
- err_unf_o  out  NB_CH  sticky: an EOT arrived with the FIFO empty.

Behaviour:
- Reset (rstn_i=0 at a clock edge) sets all FIFOs empty, all outputs 0 and all pointers 0.
- Channels are fully independent; per channel c:
  - Tag encoding: DIR_RD=1, DIR_WR=0.
  - Pushes in one cycle: rx_start_i pushes DIR_RD; tx_start_i pushes DIR_WR.
  - If both pulse in the same cycle, both tags are pushed, with RD ahead of WR (two-write-port FIFO).
  - Pop: eot_i pops the head tag.
  - Classification uses the FIFO state before this cycle's pushes. There is no bypass, so start and EOT in the same cycle on an empty FIFO counts as an underflow.
- Latency: eot_i in cycle t produces evt_rd_eot_o or evt_wr_eot_o high in cycle t+1 only (registered outputs).
- Underflow: eot_i with count=0:
  - evt_wr_eot_o pulses (the legacy default direction is write);
  - err_unf_o sets;
  - count is unchanged (a same-cycle push is still taken).
- Admission of pushes:
  - Free slots are computed as DEPTH − count + pop (the pop counts only if count>0).
  - Pushes are admitted in order RD then WR while free slots remain.
  - Each non-admitted push sets err_ovf_o and is dropped.
- Occupancy: count_next = count + admitted_pushes − valid_pop, with range 0..DEPTH.
  - Pointers are mod DEPTH; DEPTH need not be a power of 2, so wrap is explicit at DEPTH−1 → 0.
- pending_o is the registered count.
- Flush (clr_i[c]=1):
  - count, pointers, err_ovf_o and err_unf_o go to 0 next cycle;
  - all same-cycle start and EOT inputs on that channel are ignored;
  - no event is emitted.
- Sticky errors clear only on reset or on clr_i.
- Reset asserted mid-transfer discards all queued tags; outputs are 0 the cycle after the reset edge.
- No FSM beyond the FIFO itself; the per-channel state is {count, rd_ptr, wr_ptr, tag array, two sticky bits}.

Decomposition:
- Package hyper_evt_pkg holds:
  - typedef enum logic {DIR_WR=1'b0, DIR_RD=1'b1} hyper_dir_e;
  - localparam HYPER_DEFAULT_DIR = DIR_WR.
- Sub-module hyper_dir_fifo (parameter DEPTH):
  - a single-channel two-push/one-pop tag FIFO with flush, count, and overflow/underflow strobes;
  - the top instantiates it NB_CH times in a generate loop and registers the event outputs.

Test Plan:
1. rx_start c0 (cycle 1), tx_start c0 (cycle 2), eot c0 (cycles 5 and 6) → evt_rd_eot_o[0] high in cycle 6, evt_wr_eot_o[0] high in cycle 7; pending_o goes 1, 2, then back to 0; no errors.
2. rx_start[0] and tx_start[0] in the same cycle, then two EOTs → read event first, write event second; pending peaks at 2.
3. DEPTH=4: five rx_starts on c1 → pending=4, err_ovf_o[1]=1; four EOTs give four read events; a fifth EOT → write event plus err_unf_o[1]=1.
4. FIFO full (4 entries) with eot and tx_start in the same cycle → push accepted, pending stays 4, no overflow; wrap-around order is preserved over 10 mixed ops against a reference queue model.
5. Three queued tags, then clr_i[0] together with eot_i[0] → no event, pending=0 and errors=0 next cycle; channel 1 traffic in parallel is unaffected.
6. rstn_i low for 1 cycle with 2 tags pending → all outputs 0; a subsequent eot → write event plus underflow.

Source files
------------

// File: rtl/hyper_evt_pkg.sv
// ============================================================================
// Module      : hyper_evt_pkg
// Description : Shared transfer-direction tag type for the HyperBus EOT logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hyper_evt_pkg;

    typedef enum logic {
        DIR_WR = 1'b0,
        DIR_RD = 1'b1
    } hyper_dir_e;

    // Direction reported when an EOT arrives with nothing queued
    localparam hyper_dir_e HYPER_DEFAULT_DIR = DIR_WR;

endpackage

`default_nettype wire

// File: rtl/hyper_eot_classifier_if.sv
// ============================================================================
// Module      : hyper_eot_classifier_if
// Description : Start/EOT inputs and event/status outputs of the classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hyper_eot_classifier_if #(
    parameter int NB_CH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic [NB_CH-1:0]       clr_i;
    logic [NB_CH-1:0]       rx_start_i;
    logic [NB_CH-1:0]       tx_start_i;
    logic [NB_CH-1:0]       eot_i;
    logic [NB_CH-1:0]       evt_rd_eot_o;
    logic [NB_CH-1:0]       evt_wr_eot_o;
    logic [NB_CH*CNT_W-1:0] pending_o;
    logic [NB_CH-1:0]       err_ovf_o;
    logic [NB_CH-1:0]       err_unf_o;

    modport master (
        output clr_i, rx_start_i, tx_start_i, eot_i,
        input  evt_rd_eot_o, evt_wr_eot_o, pending_o, err_ovf_o, err_unf_o
    );

    modport slave (
        input  clr_i, rx_start_i, tx_start_i, eot_i,
        output evt_rd_eot_o, evt_wr_eot_o, pending_o, err_ovf_o, err_unf_o
    );
endinterface

`default_nettype wire

// File: rtl/hyper_dir_fifo.sv
// ============================================================================
// Module      : hyper_dir_fifo
// Description : Single-channel two-push/one-pop direction tag FIFO with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyper_dir_fifo
    import hyper_evt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                         sys_clk_i,
    input  wire logic                         rstn_i,
    input  wire logic                         flush_i,
    input  wire logic                         push_rd_i,
    input  wire logic                         push_wr_i,
    input  wire logic                         pop_i,
    output logic                              evt_vld_o,
    output hyper_dir_e                        evt_dir_o,
    output logic                              unf_o,
    output logic                              ovf_o,
    output logic [$clog2(DEPTH+1)-1:0]        count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0]   c_depth   = (CNT_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_max = PTR_W'(DEPTH - 1);

    hyper_dir_e       r_tags [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;

    logic             w_empty;
    logic             w_pop;
    logic             w_pop_ok;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [CNT_W:0]   w_free;
    logic [PTR_W-1:0] w_slot1;
    logic [PTR_W-1:0] w_slot_wr;

    // Explicit wrap so that non power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_ptr_max) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_empty   = (r_count == '0);
        w_pop     = pop_i & ~flush_i;
        w_pop_ok  = w_pop & ~w_empty;
        w_free    = c_depth - {1'b0, r_count} + {{CNT_W{1'b0}}, w_pop_ok};
        w_rd_ok   = push_rd_i & ~flush_i & (w_free != '0);
        w_wr_ok   = push_wr_i & ~flush_i & (w_free > {{CNT_W{1'b0}}, w_rd_ok});
        w_slot1   = ptr_inc(r_wr_ptr);
        w_slot_wr = w_rd_ok ? w_slot1 : r_wr_ptr;
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i || flush_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= r_count
                     + {{(CNT_W-1){1'b0}}, w_rd_ok}
                     + {{(CNT_W-1){1'b0}}, w_wr_ok}
                     - {{(CNT_W-1){1'b0}}, w_pop_ok};
            if (w_pop_ok)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_rd_ok && w_wr_ok)
                r_wr_ptr <= ptr_inc(w_slot1);
            else if (w_rd_ok || w_wr_ok)
                r_wr_ptr <= w_slot1;
        end
    end

    // Tag storage needs no reset: occupancy decides what is valid
    always_ff @(posedge sys_clk_i) begin
        if (w_rd_ok)
            r_tags[r_wr_ptr] <= DIR_RD;
        if (w_wr_ok)
            r_tags[w_slot_wr] <= DIR_WR;
    end

    assign evt_vld_o = w_pop;
    assign evt_dir_o = w_empty ? HYPER_DEFAULT_DIR : r_tags[r_rd_ptr];
    assign unf_o     = w_pop & w_empty;
    assign ovf_o     = (push_rd_i & ~flush_i & ~w_rd_ok) | (push_wr_i & ~flush_i & ~w_wr_ok);
    assign count_o   = r_count;

endmodule

`default_nettype wire

// File: rtl/hyper_eot_classifier.sv
// ============================================================================
// Module      : hyper_eot_classifier
// Description : Per-channel read/write EOT classifier driven by tag FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyper_eot_classifier
    import hyper_evt_pkg::*;
#(
    parameter int NB_CH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic                 sys_clk_i,
    input  wire logic                 rstn_i,
    hyper_eot_classifier_if.slave     hyper_if
);

    logic [NB_CH-1:0] w_evt_rd;
    logic [NB_CH-1:0] w_evt_wr;
    logic [NB_CH-1:0] w_unf;
    logic [NB_CH-1:0] w_ovf;

    logic [NB_CH-1:0] r_evt_rd;
    logic [NB_CH-1:0] r_evt_wr;
    logic [NB_CH-1:0] r_err_ovf;
    logic [NB_CH-1:0] r_err_unf;

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic       w_vld;
        hyper_dir_e w_dir;

        hyper_dir_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .sys_clk_i (sys_clk_i),
            .rstn_i    (rstn_i),
            .flush_i   (hyper_if.clr_i[c]),
            .push_rd_i (hyper_if.rx_start_i[c]),
            .push_wr_i (hyper_if.tx_start_i[c]),
            .pop_i     (hyper_if.eot_i[c]),
            .evt_vld_o (w_vld),
            .evt_dir_o (w_dir),
            .unf_o     (w_unf[c]),
            .ovf_o     (w_ovf[c]),
            .count_o   (hyper_if.pending_o[c*CNT_W +: CNT_W])
        );

        assign w_evt_rd[c] = w_vld & (w_dir == DIR_RD);
        assign w_evt_wr[c] = w_vld & (w_dir == DIR_WR);
    end

    // FIFO strobes are already masked by flush; only the sticky bits need clearing
    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i) begin
            r_evt_rd  <= '0;
            r_evt_wr  <= '0;
            r_err_ovf <= '0;
            r_err_unf <= '0;
        end else begin
            r_evt_rd  <= w_evt_rd;
            r_evt_wr  <= w_evt_wr;
            r_err_ovf <= (r_err_ovf | w_ovf) & ~hyper_if.clr_i;
            r_err_unf <= (r_err_unf | w_unf) & ~hyper_if.clr_i;
        end
    end

    assign hyper_if.evt_rd_eot_o = r_evt_rd;
    assign hyper_if.evt_wr_eot_o = r_evt_wr;
    assign hyper_if.err_ovf_o    = r_err_ovf;
    assign hyper_if.err_unf_o    = r_err_unf;

endmodule

`default_nettype wire

// File: tb/tb_hyper_eot_classifier.sv
// ============================================================================
// Module      : tb_hyper_eot_classifier
// Description : Directed self-checking bench for hyper_eot_classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hyper_eot_classifier;
    import hyper_evt_pkg::*;

    localparam int NB_CH = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic sys_clk_i = 1'b0;
    logic rstn_i    = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    // Reference queue for channel 0 in the mixed-operation section
    hyper_dir_e q_ref[$];
    logic       m_ovf;
    logic       m_unf;

    hyper_eot_classifier_if #(.NB_CH(NB_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) hif ();

    hyper_eot_classifier #(
        .NB_CH (NB_CH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .sys_clk_i (sys_clk_i),
        .rstn_i    (rstn_i),
        .hyper_if  (hif)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    function automatic logic [31:0] pend(input int c1, input int c0);
        logic [5:0] v;
        v = {3'(c1), 3'(c0)};
        return {26'd0, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are stable 1 time unit after the edge
    task automatic cyc(input logic [1:0] rx, input logic [1:0] tx,
                       input logic [1:0] eot, input logic [1:0] clr);
        hif.rx_start_i = rx;
        hif.tx_start_i = tx;
        hif.eot_i      = eot;
        hif.clr_i      = clr;
        @(posedge sys_clk_i);
        #1;
        hif.rx_start_i = '0;
        hif.tx_start_i = '0;
        hif.eot_i      = '0;
        hif.clr_i      = '0;
    endtask

    task automatic chk_evt(input string tag, input logic [1:0] rd, input logic [1:0] wr);
        chk({tag, "_rd"}, 32'(hif.evt_rd_eot_o), 32'(rd));
        chk({tag, "_wr"}, 32'(hif.evt_wr_eot_o), 32'(wr));
    endtask

    task automatic mop(input string tag, input logic rx, input logic tx, input logic eot);
        logic e_rd;
        logic e_wr;
        hyper_dir_e d;
        e_rd = 1'b0;
        e_wr = 1'b0;
        if (eot) begin
            if (q_ref.size() > 0) begin
                d = q_ref.pop_front();
                if (d == DIR_RD) e_rd = 1'b1; else e_wr = 1'b1;
            end else begin
                e_wr  = 1'b1;
                m_unf = 1'b1;
            end
        end
        if (rx) begin
            if (q_ref.size() < DEPTH) q_ref.push_back(DIR_RD); else m_ovf = 1'b1;
        end
        if (tx) begin
            if (q_ref.size() < DEPTH) q_ref.push_back(DIR_WR); else m_ovf = 1'b1;
        end
        cyc({1'b0, rx}, {1'b0, tx}, {1'b0, eot}, 2'b00);
        chk_evt(tag, {1'b0, e_rd}, {1'b0, e_wr});
        chk({tag, "_pend"}, 32'(hif.pending_o), pend(0, q_ref.size()));
        chk({tag, "_ovf"}, 32'(hif.err_ovf_o), {31'd0, m_ovf});
        chk({tag, "_unf"}, 32'(hif.err_unf_o), {31'd0, m_unf});
    endtask

    initial begin
        hif.rx_start_i = '0;
        hif.tx_start_i = '0;
        hif.eot_i      = '0;
        hif.clr_i      = '0;

        // Reset state
        rstn_i = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        rstn_i = 1'b1;
        chk("rst_pend", 32'(hif.pending_o), pend(0, 0));
        chk_evt("rst_evt", 2'b00, 2'b00);
        chk("rst_ovf", 32'(hif.err_ovf_o), 32'd0);
        chk("rst_unf", 32'(hif.err_unf_o), 32'd0);

        // RD then WR on separate cycles, two EOTs
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        chk("t1_pend1", 32'(hif.pending_o), pend(0, 1));
        cyc(2'b00, 2'b01, 2'b00, 2'b00);
        chk("t1_pend2", 32'(hif.pending_o), pend(0, 2));
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        chk_evt("t1_idle", 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b01, 2'b00);
        chk_evt("t1_eot1", 2'b01, 2'b00);
        chk("t1_pend3", 32'(hif.pending_o), pend(0, 1));
        cyc(2'b00, 2'b00, 2'b01, 2'b00);
        chk_evt("t1_eot2", 2'b00, 2'b01);
        chk("t1_pend4", 32'(hif.pending_o), pend(0, 0));
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        chk_evt("t1_after", 2'b00, 2'b00);
        chk("t1_ovf", 32'(hif.err_ovf_o), 32'd0);
        chk("t1_unf", 32'(hif.err_unf_o), 32'd0);

        // Simultaneous RD + WR starts: RD is queued ahead
        cyc(2'b01, 2'b01, 2'b00, 2'b00);
        chk("t2_pend", 32'(hif.pending_o), pend(0, 2));
        cyc(2'b00, 2'b00, 2'b01, 2'b00);
        chk_evt("t2_eot1", 2'b01, 2'b00);
        cyc(2'b00, 2'b00, 2'b01, 2'b00);
        chk_evt("t2_eot2", 2'b00, 2'b01);
        chk("t2_pend0", 32'(hif.pending_o), pend(0, 0));

        // Overflow then underflow on channel 1
        for (int i = 0; i < 5; i++) cyc(2'b10, 2'b00, 2'b00, 2'b00);
        chk("t3_pend", 32'(hif.pending_o), pend(4, 0));
        chk("t3_ovf", 32'(hif.err_ovf_o), 32'b10);
        chk("t3_unf0", 32'(hif.err_unf_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b00, 2'b00, 2'b10, 2'b00);
            chk_evt("t3_drain", 2'b10, 2'b00);
        end
        cyc(2'b00, 2'b00, 2'b10, 2'b00);
        chk_evt("t3_unf_evt", 2'b00, 2'b10);
        chk("t3_unf", 32'(hif.err_unf_o), 32'b10);
        chk("t3_pend0", 32'(hif.pending_o), pend(0, 0));
        cyc(2'b00, 2'b00, 2'b00, 2'b10);
        chk("t3_clr_ovf", 32'(hif.err_ovf_o), 32'd0);
        chk("t3_clr_unf", 32'(hif.err_unf_o), 32'd0);

        // Full FIFO with same-cycle pop/push, then mixed ops against the queue model
        m_ovf = 1'b0;
        m_unf = 1'b0;
        mop("t4_fill_a", 1'b1, 1'b1, 1'b0);
        mop("t4_fill_b", 1'b1, 1'b1, 1'b0);
        mop("t4_full_pp", 1'b0, 1'b1, 1'b1);
        mop("t4_m01", 1'b1, 1'b0, 1'b1);
        mop("t4_m02", 1'b0, 1'b1, 1'b1);
        mop("t4_m03", 1'b1, 1'b1, 1'b1);
        mop("t4_m04", 1'b0, 1'b0, 1'b1);
        mop("t4_m05", 1'b0, 1'b0, 1'b1);
        mop("t4_m06", 1'b1, 1'b0, 1'b0);
        mop("t4_m07", 1'b0, 1'b0, 1'b1);
        mop("t4_m08", 1'b0, 1'b0, 1'b1);
        mop("t4_m09", 1'b0, 1'b0, 1'b1);
        mop("t4_m10", 1'b0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 2'b01);
        chk("t4_clr_err", 32'({hif.err_ovf_o, hif.err_unf_o}), 32'd0);

        // Flush with a coincident EOT; channel 1 keeps working
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b11, 2'b00, 2'b00, 2'b00);
        chk("t5_pend", 32'(hif.pending_o), pend(1, 3));
        cyc(2'b00, 2'b00, 2'b11, 2'b01);
        chk_evt("t5_flush", 2'b10, 2'b00);
        chk("t5_pend0", 32'(hif.pending_o), pend(0, 0));
        chk("t5_err", 32'({hif.err_ovf_o, hif.err_unf_o}), 32'd0);

        // Reset with queued tags; the next EOT underflows
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b01, 2'b00, 2'b00);
        chk("t6_pend", 32'(hif.pending_o), pend(0, 2));
        rstn_i = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        rstn_i = 1'b1;
        chk("t6_rst_pend", 32'(hif.pending_o), pend(0, 0));
        chk_evt("t6_rst_evt", 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b01, 2'b00);
        chk_evt("t6_eot", 2'b00, 2'b01);
        chk("t6_unf", 32'(hif.err_unf_o), 32'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
